// File: rtl/bp_me_stream_fanin_pkg.sv
// bp_me_stream_fanin_pkg: shared fwd-state encodings and id-width helper for the stream fan-in
package bp_me_stream_fanin_pkg;
  localparam logic [0:0] e_unlocked = 1'b0;
  localparam logic [0:0] e_locked   = 1'b1;
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bp_me_stream_tag_fifo.sv
// bp_me_stream_tag_fifo: register FIFO of channel ids with full/empty and same-cycle push/pop
module bp_me_stream_tag_fifo
  import bp_me_stream_fanin_pkg::*;
#(
  parameter int width_p = 1,
  parameter int els_p = 4,
  localparam int ptr_w_lp = safe_clog2(els_p),
  localparam int cnt_w_lp = $clog2(els_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               push_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);
  logic [width_p-1:0] mem_r [els_p];
  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic [cnt_w_lp-1:0] count_r;
  function automatic logic [ptr_w_lp-1:0] inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk_i)
    if (push_i) mem_r[wptr_r] <= data_i;
  always_ff @(posedge clk_i)
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_i) wptr_r <= inc(wptr_r);
      if (pop_i) rptr_r <= inc(rptr_r);
      count_r <= count_r + cnt_w_lp'(push_i) - cnt_w_lp'(pop_i);
    end
  assign data_o  = mem_r[rptr_r];
  assign full_o  = count_r == cnt_w_lp'(els_p);
  assign empty_o = count_r == '0;
endmodule

// File: rtl/bp_me_stream_fanin.sv
// bp_me_stream_fanin: round-robin burst-locked fan-in of N mem streams with in-order rev routing
module bp_me_stream_fanin
  import bp_me_stream_fanin_pkg::*;
#(
  parameter int num_ch_p = 2,
  parameter int header_width_p = 64,
  parameter int data_width_p = 64,
  parameter int max_outstanding_p = 4,
  localparam int lg_num_ch_lp = safe_clog2(num_ch_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [num_ch_p*header_width_p-1:0] mem_fwd_header_i,
  input  logic [num_ch_p*data_width_p-1:0]   mem_fwd_data_i,
  input  logic [num_ch_p-1:0]                mem_fwd_last_i,
  input  logic [num_ch_p-1:0]                mem_fwd_v_i,
  output logic [num_ch_p-1:0]                mem_fwd_ready_and_o,
  output logic [header_width_p-1:0]          mem_fwd_header_o,
  output logic [data_width_p-1:0]            mem_fwd_data_o,
  output logic                               mem_fwd_last_o,
  output logic                               mem_fwd_v_o,
  input  logic                               mem_fwd_ready_and_i,
  input  logic [header_width_p-1:0]          mem_rev_header_i,
  input  logic [data_width_p-1:0]            mem_rev_data_i,
  input  logic                               mem_rev_last_i,
  input  logic                               mem_rev_v_i,
  output logic                               mem_rev_ready_and_o,
  output logic [num_ch_p*header_width_p-1:0] mem_rev_header_o,
  output logic [num_ch_p*data_width_p-1:0]   mem_rev_data_o,
  output logic [num_ch_p-1:0]                mem_rev_last_o,
  output logic [num_ch_p-1:0]                mem_rev_v_o,
  input  logic [num_ch_p-1:0]                mem_rev_ready_and_i,
  output logic                               error_o
);
  logic [0:0] state_r;
  logic [lg_num_ch_lp-1:0] grant_r, rr_ptr_r, grant_c, idx, sel, nxt, owner;
  logic locked, tag_full, tag_empty, fwd_hs, push, pop, rev_active;
  assign locked = state_r == e_locked;
  // first valid channel at or after the round-robin pointer, with wrap
  always_comb begin
    idx = '0;
    grant_c = rr_ptr_r;
    for (int i = num_ch_p - 1; i >= 0; i--) begin
      idx = lg_num_ch_lp'((int'(rr_ptr_r) + i) % num_ch_p);
      if (mem_fwd_v_i[idx]) grant_c = idx;
    end
  end
  assign sel = locked ? grant_r : grant_c;
  assign nxt = (sel == lg_num_ch_lp'(num_ch_p - 1)) ? '0 : sel + 1'b1;
  assign mem_fwd_v_o      = ~reset_i & (locked ? mem_fwd_v_i[sel] : (|mem_fwd_v_i & ~tag_full));
  assign mem_fwd_header_o = mem_fwd_header_i[sel*header_width_p +: header_width_p];
  assign mem_fwd_data_o   = mem_fwd_data_i[sel*data_width_p +: data_width_p];
  assign mem_fwd_last_o   = mem_fwd_last_i[sel];
  assign fwd_hs = mem_fwd_v_o & mem_fwd_ready_and_i;
  assign push   = fwd_hs & ~locked;
  assign rev_active = ~reset_i & ~tag_empty;
  assign mem_rev_ready_and_o = rev_active & mem_rev_ready_and_i[owner];
  assign pop = mem_rev_v_i & mem_rev_ready_and_o & mem_rev_last_i;
  assign mem_rev_header_o = {num_ch_p{mem_rev_header_i}};
  assign mem_rev_data_o   = {num_ch_p{mem_rev_data_i}};
  assign mem_rev_last_o   = {num_ch_p{mem_rev_last_i}};
  always_comb begin
    mem_fwd_ready_and_o = '0;
    mem_rev_v_o = '0;
    for (int c = 0; c < num_ch_p; c++) begin
      mem_fwd_ready_and_o[c] = ~reset_i & (sel == lg_num_ch_lp'(c)) & mem_fwd_ready_and_i & (locked | ~tag_full);
      mem_rev_v_o[c] = rev_active & mem_rev_v_i & (owner == lg_num_ch_lp'(c));
    end
  end
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state_r  <= e_unlocked;
      grant_r  <= '0;
      rr_ptr_r <= '0;
      error_o  <= 1'b0;
    end else begin
      if (fwd_hs & mem_fwd_last_i[sel]) begin
        state_r  <= e_unlocked;
        rr_ptr_r <= nxt;
      end else if (push) begin
        state_r <= e_locked;
        grant_r <= grant_c;
      end
      if (mem_rev_v_i & tag_empty) error_o <= 1'b1;
    end
  bp_me_stream_tag_fifo #(.width_p(lg_num_ch_lp), .els_p(max_outstanding_p)) tags (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .data_i(grant_c),
    .push_i(push),
    .pop_i(pop),
    .data_o(owner),
    .full_o(tag_full),
    .empty_o(tag_empty)
  );
endmodule
